// File: rtl/mux2x1_pkg.sv
// Shared defaults and select encoding for the registered 2:1 mux.
package mux2x1_pkg;

    localparam int DATAWIDTH_DEF = 8;
    localparam int CNTWIDTH_DEF  = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2x1_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNTWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    output logic [CNTWIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNTWIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux2x1.sv
// Registered 2:1 mux with per-source capture counters.
// Optional even-parity output d_par is built when MUX2X1_PARITY_EN is defined.
module mux2x1
    import mux2x1_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int CNTWIDTH  = CNTWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 sel,
    input  logic                 en,
    output logic [DATAWIDTH-1:0] d,
    output logic                 d_valid,
    output logic                 sel_q,
    output logic [CNTWIDTH-1:0]  cnt_a,
    output logic [CNTWIDTH-1:0]  cnt_b
`ifdef MUX2X1_PARITY_EN
    ,
    output logic                 d_par
`endif
);

    logic                 take_b;
    logic [DATAWIDTH-1:0] d_next;

    // Anything other than a clean 1 on sel selects source a.
    always_comb begin
        take_b = SEL_A;
        if (sel == SEL_B) begin
            take_b = SEL_B;
        end
        d_next = take_b ? b : a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d       <= '0;
            d_valid <= 1'b0;
            sel_q   <= SEL_A;
        end else begin
            d_valid <= en;
            if (en) begin
                d     <= d_next;
                sel_q <= take_b;
            end
        end
    end

`ifdef MUX2X1_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            d_par <= 1'b0;
        end else if (en) begin
            d_par <= ^d_next;
        end
    end
`endif

    sat_counter #(.CNTWIDTH(CNTWIDTH)) u_cnt_a (
        .clk (clk),
        .rst (rst),
        .inc (en & ~take_b),
        .cnt (cnt_a)
    );

    sat_counter #(.CNTWIDTH(CNTWIDTH)) u_cnt_b (
        .clk (clk),
        .rst (rst),
        .inc (en & take_b),
        .cnt (cnt_b)
    );

endmodule

// File: tb/tb_mux2x1.sv
// Directed bench for mux2x1: default-width instance plus a 2-bit-counter instance for saturation.
module tb_mux2x1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic       en;

    logic [7:0]  d;
    logic        d_valid;
    logic        sel_q;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    logic [7:0] s_d;
    logic       s_d_valid;
    logic       s_sel_q;
    logic [1:0] s_cnt_a;
    logic [1:0] s_cnt_b;

`ifdef MUX2X1_PARITY_EN
    logic d_par;
    logic s_d_par;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mux2x1 #(.DATAWIDTH(8), .CNTWIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .en      (en),
        .d       (d),
        .d_valid (d_valid),
        .sel_q   (sel_q),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
`ifdef MUX2X1_PARITY_EN
        ,
        .d_par   (d_par)
`endif
    );

    mux2x1 #(.DATAWIDTH(8), .CNTWIDTH(2)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .en      (en),
        .d       (s_d),
        .d_valid (s_d_valid),
        .sel_q   (s_sel_q),
        .cnt_a   (s_cnt_a),
        .cnt_b   (s_cnt_b)
`ifdef MUX2X1_PARITY_EN
        ,
        .d_par   (s_d_par)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] ed, input logic ev,
                             input logic es, input logic [15:0] ea, input logic [15:0] eb);
        check({tag, ".d"},       32'(d),       32'(ed));
        check({tag, ".d_valid"}, 32'(d_valid), 32'(ev));
        check({tag, ".sel_q"},   32'(sel_q),   32'(es));
        check({tag, ".cnt_a"},   32'(cnt_a),   32'(ea));
        check({tag, ".cnt_b"},   32'(cnt_b),   32'(eb));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a = 8'd0; b = 8'd0; sel = 1'b0;
        tick();
        tick();
        check_all("reset", 8'd0, 1'b0, 1'b0, 16'd0, 16'd0);

        // Capture a.
        rst = 1'b0; a = 8'd20; b = 8'd10; sel = 1'b0; en = 1'b1;
        tick();
        check_all("cap_a", 8'd20, 1'b1, 1'b0, 16'd1, 16'd0);

        // Input change between edges must not reach d.
        a = 8'd99;
        #2;
        check("no_comb.d", 32'(d), 32'd20);

        // Capture b, then new b.
        a = 8'd20; sel = 1'b1;
        tick();
        check_all("cap_b", 8'd10, 1'b1, 1'b1, 16'd1, 16'd1);
        b = 8'd30;
        tick();
        check_all("cap_b30", 8'd30, 1'b1, 1'b1, 16'd1, 16'd2);

        a = 8'd15; sel = 1'b0;
        tick();
        check_all("cap_a15", 8'd15, 1'b1, 1'b0, 16'd2, 16'd2);

        // Hold while disabled, even with inputs moving.
        en = 1'b0; a = 8'd77; b = 8'd88; sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("hold%0d", i), 8'd15, 1'b0, 1'b0, 16'd2, 16'd2);
        end

        // sel and data change together: values at the edge are used.
        en = 1'b1; sel = 1'b1; b = 8'd55;
        tick();
        check_all("simul", 8'd55, 1'b1, 1'b1, 16'd2, 16'd3);

        // Reset mid-stream discards the capture.
        rst = 1'b1; en = 1'b1; sel = 1'b1; b = 8'd30;
        tick();
        check_all("rst_mid", 8'd0, 1'b0, 1'b0, 16'd0, 16'd0);
        rst = 1'b0;
        tick();
        check_all("post_rst", 8'd30, 1'b1, 1'b1, 16'd0, 16'd1);

        // Saturation on the 2-bit instance.
        rst = 1'b1;
        tick();
        rst = 1'b0; sel = 1'b1; en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            tick();
            check($sformatf("sat%0d.s_cnt_b", i), 32'(s_cnt_b), (i > 3) ? 32'd3 : 32'(i));
            check($sformatf("sat%0d.cnt_b", i),   32'(cnt_b),   32'(i));
        end
        check("sat.s_cnt_a", 32'(s_cnt_a), 32'd0);
        check("sat.s_d", 32'(s_d), 32'd4);

`ifdef MUX2X1_PARITY_EN
        rst = 1'b1;
        tick();
        check("par_rst", 32'(d_par), 32'd0);
        rst = 1'b0; a = 8'h07; sel = 1'b0; en = 1'b1;
        tick();
        check("par_07", 32'(d_par), 32'd1);
        a = 8'h03;
        tick();
        check("par_03", 32'(d_par), 32'd0);
        en = 1'b0; a = 8'h01;
        tick();
        check("par_hold", 32'(d_par), 32'd0);
        en = 1'b1; sel = 1'b1; b = 8'hFE;
        tick();
        check("par_fe", 32'(d_par), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mux2x1.md
MUX2X1 -- requirements
Module: mux2x1

Interface
REQ-001 The module SHALL take parameter DATAWIDTH, default 8: width of data inputs and output.
REQ-002 The module SHALL take parameter CNTWIDTH, default 16: width of each selection counter.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk SHALL be an input, 1 bit: the rising-edge clock.
REQ-005 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 Port a SHALL be an input, DATAWIDTH bits: data source 0.
REQ-007 Port b SHALL be an input, DATAWIDTH bits: data source 1.
REQ-008 Port sel SHALL be an input, 1 bit: source select, 0 chooses a and 1 chooses b.
REQ-009 Port en SHALL be an input, 1 bit: capture enable.
REQ-010 Port d SHALL be an output, DATAWIDTH bits: registered mux result.
REQ-011 Port d_valid SHALL be an output, 1 bit: high when d was updated on the last edge.
REQ-012 Port sel_q SHALL be an output, 1 bit: registered copy of the select used for d.
REQ-013 Port cnt_a SHALL be an output, CNTWIDTH bits: count of captures of a.
REQ-014 Port cnt_b SHALL be an output, CNTWIDTH bits: count of captures of b.
REQ-015 Port d_par SHALL be an output, 1 bit, present only with MUX2X1_PARITY_EN: even parity of d.

Function
REQ-016 On a rising clk edge with rst=0 and en=1, d SHALL load b if sel=1, else a.
- Latency: exactly 1 cycle.
REQ-017 On the same edge, d_valid SHALL load 1 and sel_q SHALL load sel.
REQ-018 On an edge with rst=0 and en=0, d and sel_q SHALL hold their values and d_valid SHALL load 0.
REQ-019 On each enabled capture, cnt_a SHALL increment when sel=0 and cnt_b SHALL increment when sel=1.
REQ-020 Each counter SHALL saturate at all-ones and never wrap.
REQ-021 Changes on a, b or sel between edges SHALL NOT affect d; there SHALL be no combinational path from inputs to outputs.
REQ-022 A change of sel together with a change of data in the same cycle SHALL use the values present at the edge.
REQ-023 sel values X or Z are out of scope; the design SHALL treat any non-1 sel as 0.

Reset
REQ-024 On an edge with rst=1, regardless of en, the outputs SHALL take these values:
- d=0, d_valid=0, sel_q=0, cnt_a=0, cnt_b=0;
- d_par=0 when MUX2X1_PARITY_EN is defined.
REQ-025 Reset asserted mid-stream SHALL discard the capture of that edge; the first capture after deassertion SHALL occur on the first edge with rst=0 and en=1.

Configuration
REQ-026 The optional feature SHALL be controlled by macro MUX2X1_PARITY_EN.
- Defined: port d_par exists and is registered alongside d, equal to the XOR of all bits of the next d value, holding when en=0.
- Undefined: port d_par and its logic are absent, and all other behaviour is identical.

Structure
REQ-027 A shared package mux2x1_pkg SHALL hold the DATAWIDTH and CNTWIDTH defaults and the constant SEL_A=0, SEL_B=1.
REQ-028 The saturating counter SHALL be a sub-module sat_counter, instantiated twice (for a and for b).

Verification
REQ-029 Reset, then a=20, b=10, sel=0, en=1 -> after 1 edge d=20, d_valid=1, sel_q=0, cnt_a=1.
REQ-030 sel=1 with a=20, b=10 -> next edge d=10, sel_q=1, cnt_b=1; then b=30 -> next edge d=30.
REQ-031 a=15, sel=0 -> next edge d=15; en=0 for 3 edges -> d stays 15, d_valid=0, counters unchanged.
REQ-032 Saturation: with CNTWIDTH=2, four captures with sel=1 -> cnt_b=3 on the 3rd and 4th capture.
REQ-033 rst=1 with en=1, sel=1, b=30 -> next edge all outputs 0; rst=0 -> next edge d=30.
REQ-034 With MUX2X1_PARITY_EN defined, a=8'h07, sel=0, en=1 -> d_par=1; then a=8'h03 -> d_par=0.
